// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream decryptor: the sequencer
// state encoding, the default message length and the plaintext
// character bounds used by the optional key check (RC4_ASCII_CHECK_EN).
package rc4_pkg;

    localparam int MSG_LEN_DEFAULT = 32;

    // Accepted plaintext alphabet: space plus lower-case letters.
    localparam logic [7:0] ASCII_SPACE     = 8'h20;
    localparam logic [7:0] ASCII_LOWER_MIN = 8'h61;
    localparam logic [7:0] ASCII_LOWER_MAX = 8'h7A;

    // One state per memory access / register step; every byte walks
    // INC_I .. WR_OUT, which is exactly ten cycles.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_INC_I  = 4'd1,
        ST_REQ_SI = 4'd2,
        ST_REG_SI = 4'd3,
        ST_REQ_SJ = 4'd4,
        ST_REG_SJ = 4'd5,
        ST_WR_J   = 4'd6,
        ST_WR_I   = 4'd7,
        ST_REQ_F  = 4'd8,
        ST_REG_F  = 4'd9,
        ST_WR_OUT = 4'd10,
        ST_DONE   = 4'd11
    } state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext classifier: flags a byte as valid when it is
// a space or a lower-case ASCII letter. Used by rc4_decrypt only when
// RC4_ASCII_CHECK_EN is defined.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] i_char,
    output logic       o_valid
);

    assign o_valid = (i_char == ASCII_SPACE) ||
                     ((i_char >= ASCII_LOWER_MIN) && (i_char <= ASCII_LOWER_MAX));

endmodule

// File: rtl/rc4_decrypt.sv
// RC4 PRGA decryptor working on an external, already key-scheduled S-RAM.
// For each message byte k it advances i/j, swaps S[i]/S[j], reads the
// keystream byte f = S[S[i]+S[j]] and writes f XOR enc[k] to the output
// RAM. Both RAMs have one cycle of read latency.
// Optional build macro RC4_ASCII_CHECK_EN: abort the run and raise
// key_invalid as soon as a decrypted byte falls outside {space, a..z}.
module rc4_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] s_data_in,
    output logic [7:0] s_addr,
    output logic [7:0] s_data_out,
    output logic       s_write,
    output logic [7:0] msg_addr,
    input  logic [7:0] msg_data_in,
    output logic [7:0] out_addr,
    output logic [7:0] out_data,
    output logic       out_write,
    output logic       decrypt_finish,
    output logic       key_invalid
);

    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_k;
    logic [7:0] r_s_i;
    logic [7:0] r_s_j;
    logic [7:0] r_f;
    logic [7:0] r_enc;

    logic [7:0] w_plain;
    logic       w_last;
    logic       w_abort;

    assign w_plain = r_f ^ r_enc;
    assign w_last  = (r_k == LAST_K);

`ifdef RC4_ASCII_CHECK_EN
    logic w_char_ok;
    logic r_key_invalid;

    rc4_char_check u_char_check (
        .i_char  (w_plain),
        .o_valid (w_char_ok)
    );

    assign w_abort     = ~w_char_ok;
    assign key_invalid = r_key_invalid;

    // Key-check flag: cleared when a run starts, set when a byte is rejected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_invalid <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_key_invalid <= 1'b0;
        end else if ((r_state == ST_WR_OUT) && w_abort) begin
            r_key_invalid <= 1'b1;
        end
    end
`else
    assign w_abort     = 1'b0;
    assign key_invalid = 1'b0;
`endif

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PRGA datapath: index updates and registration of RAM read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i   <= 8'd0;
            r_j   <= 8'd0;
            r_k   <= 8'd0;
            r_s_i <= 8'd0;
            r_s_j <= 8'd0;
            r_f   <= 8'd0;
            r_enc <= 8'd0;
        end else begin
            case (r_state)
                ST_INC_I: begin
                    r_i <= r_i + 8'd1;
                end
                ST_REG_SI: begin
                    r_s_i <= s_data_in;
                    r_j   <= r_j + s_data_in;
                end
                ST_REG_SJ: begin
                    r_s_j <= s_data_in;
                end
                ST_REG_F: begin
                    r_f   <= s_data_in;
                    r_enc <= msg_data_in;
                end
                ST_WR_OUT: begin
                    if (!w_last && !w_abort) begin
                        r_k <= r_k + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_i <= 8'd0;
                    r_j <= 8'd0;
                    r_k <= 8'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and Moore outputs for the RAM ports and strobes.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next   = r_state;
        s_addr         = 8'd0;
        s_data_out     = 8'd0;
        s_write        = 1'b0;
        msg_addr       = 8'd0;
        out_addr       = 8'd0;
        out_data       = 8'd0;
        out_write      = 1'b0;
        decrypt_finish = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_INC_I;
                end
            end
            ST_INC_I: begin
                w_state_next = ST_REQ_SI;
            end
            ST_REQ_SI: begin
                s_addr       = r_i;
                w_state_next = ST_REG_SI;
            end
            ST_REG_SI: begin
                w_state_next = ST_REQ_SJ;
            end
            ST_REQ_SJ: begin
                s_addr       = r_j;
                w_state_next = ST_REG_SJ;
            end
            ST_REG_SJ: begin
                w_state_next = ST_WR_J;
            end
            // When i == j both writes land on one address with one value,
            // so the swap degenerates correctly without a special case.
            ST_WR_J: begin
                s_addr       = r_j;
                s_data_out   = r_s_i;
                s_write      = 1'b1;
                w_state_next = ST_WR_I;
            end
            ST_WR_I: begin
                s_addr       = r_i;
                s_data_out   = r_s_j;
                s_write      = 1'b1;
                w_state_next = ST_REQ_F;
            end
            ST_REQ_F: begin
                s_addr       = r_s_i + r_s_j;
                msg_addr     = r_k;
                w_state_next = ST_REG_F;
            end
            ST_REG_F: begin
                w_state_next = ST_WR_OUT;
            end
            ST_WR_OUT: begin
                out_addr  = r_k;
                out_data  = w_plain;
                out_write = 1'b1;
                if (w_last || w_abort) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_INC_I;
                end
            end
            ST_DONE: begin
                decrypt_finish = 1'b1;
                w_state_next   = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rc4_decrypt.sv
// Directed bench for rc4_decrypt: behavioural S-RAM / message ROM with
// one cycle of read latency, a straightforward RC4 PRGA reference
// function, and directed runs on an identity S-box. Expectations follow
// the RC4_ASCII_CHECK_EN setting of the build.
module tb_rc4_decrypt;

    localparam int MSG_LEN = 32;
    localparam int BUDGET  = 400;

`ifdef RC4_ASCII_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef logic [7:0] mem_t [256];

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] s_data_in;
    logic [7:0] s_addr;
    logic [7:0] s_data_out;
    logic       s_write;
    logic [7:0] msg_addr;
    logic [7:0] msg_data_in;
    logic [7:0] out_addr;
    logic [7:0] out_data;
    logic       out_write;
    logic       decrypt_finish;
    logic       key_invalid;

    mem_t s_mem;
    mem_t s_init;
    mem_t enc_mem;
    mem_t out_buf;
    logic s_load;

    int   n_vectors     = 0;
    int   n_miscompares = 0;
    int   n_writes;
    int   first_out_addr;
    logic kinv_at_fin;

    rc4_decrypt #(.MSG_LEN(MSG_LEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .s_data_in      (s_data_in),
        .s_addr         (s_addr),
        .s_data_out     (s_data_out),
        .s_write        (s_write),
        .msg_addr       (msg_addr),
        .msg_data_in    (msg_data_in),
        .out_addr       (out_addr),
        .out_data       (out_data),
        .out_write      (out_write),
        .decrypt_finish (decrypt_finish),
        .key_invalid    (key_invalid)
    );

    always #5 clk = ~clk;

    // Synchronous S-RAM and message ROM with registered read data.
    always @(posedge clk) begin
        if (s_load) begin
            for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
        end else if (s_write) begin
            s_mem[s_addr] <= s_data_out;
        end
        s_data_in   <= s_mem[s_addr];
        msg_data_in <= enc_mem[msg_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference RC4 PRGA starting from i=j=0 on the given S.
    function automatic void rc4_model(input mem_t s_start, input mem_t enc, input bit chk,
                                      output mem_t pt, output mem_t s_end, output int n_out);
        logic [7:0] i, j, t, idx, p;
        mem_t s;
        s = s_start;
        i = 8'd0;
        j = 8'd0;
        n_out = 0;
        for (int x = 0; x < 256; x++) pt[x] = 8'd0;
        for (int k = 0; k < MSG_LEN; k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            idx = s[i] + s[j];
            p = s[idx] ^ enc[k];
            pt[k] = p;
            n_out = k + 1;
            if (chk && !(p == 8'h20 || (p >= 8'h61 && p <= 8'h7A))) break;
        end
        s_end = s;
    endfunction

    function automatic int count_diff(input mem_t a, input mem_t b, input int n);
        int d = 0;
        for (int x = 0; x < n; x++) if (a[x] !== b[x]) d++;
        return d;
    endfunction

    task automatic load_identity();
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
        s_load = 1'b1;
        @(negedge clk);
        s_load = 1'b0;
    endtask

    // Start a run from IDLE (called at a negedge) and capture output
    // writes until decrypt_finish; cycle 1 is the cycle after start is sampled.
    task automatic do_run(input bit hold_at_done, input int pulse_at, output int fin_cycle);
        int c;
        fin_cycle      = -1;
        n_writes       = 0;
        first_out_addr = -1;
        kinv_at_fin    = 1'bx;
        for (int x = 0; x < 256; x++) out_buf[x] = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c <= BUDGET) begin
            if (pulse_at > 0) start = (c >= pulse_at) && (c < pulse_at + 3);
            if (out_write) begin
                if (n_writes == 0) first_out_addr = int'(out_addr);
                out_buf[out_addr] = out_data;
                n_writes++;
            end
            if (decrypt_finish) begin
                fin_cycle   = c;
                kinv_at_fin = key_invalid;
                if (hold_at_done) start = 1'b1;
                break;
            end
            @(negedge clk);
            c++;
        end
        if (fin_cycle < 0) $display("FAIL run_timeout: got no finish expected finish within %0d cycles", BUDGET);
    endtask

    mem_t zeros, ks, enc_valid, enc_use, exp_pt, exp_s, s_after, dummy_s;
    int   exp_n, fin;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        s_load = 1'b0;
        for (int a = 0; a < 256; a++) begin
            zeros[a]   = 8'd0;
            enc_mem[a] = 8'd0;
            s_init[a]  = 8'(a);
        end

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_s_write",   32'(s_write),        32'd0);
        check("rst_out_write", 32'(out_write),      32'd0);
        check("rst_finish",    32'(decrypt_finish), 32'd0);
        check("rst_key_inv",   32'(key_invalid),    32'd0);
        check("rst_s_addr",    32'(s_addr),         32'd0);
        load_identity();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_strobes", {29'd0, s_write, out_write, decrypt_finish}, 32'd0);

        // Keystream of the identity S-box.
        rc4_model(s_init, zeros, 1'b0, ks, dummy_s, exp_n);
        for (int a = 0; a < 256; a++) enc_valid[a] = ks[a] ^ 8'h61;

        // Run A: identity S, all-zero ciphertext.
        rc4_model(s_init, zeros, CHK, exp_pt, exp_s, exp_n);
        do_run(1'b0, 0, fin);
        check("a_out0", 32'(out_buf[0]), 32'h02);
        check("a_first_addr", 32'(first_out_addr), 32'd0);
`ifdef RC4_ASCII_CHECK_EN
        check("a_fin_cycle", 32'(fin), 32'd11);
        check("a_n_writes", 32'(n_writes), 32'd1);
        check("a_key_inv", 32'(kinv_at_fin), 32'd1);
`else
        check("a_out1", 32'(out_buf[1]), 32'h05);
        check("a_out2", 32'(out_buf[2]), 32'h07);
        check("a_fin_cycle", 32'(fin), 32'd321);
        check("a_n_writes", 32'(n_writes), 32'd32);
        check("a_key_inv", 32'(kinv_at_fin), 32'd0);
`endif
        check("a_pt_vs_model", 32'(count_diff(out_buf, exp_pt, exp_n)), 32'd0);
        check("a_sram_vs_model", 32'(count_diff(s_mem, exp_s, 256)), 32'd0);
        @(negedge clk);
        check("a_finish_one_cycle", 32'(decrypt_finish), 32'd0);

        // Run B: ciphertext chosen so every plaintext byte is 'a'.
        load_identity();
        enc_mem = enc_valid;
        do_run(1'b0, 0, fin);
        check("b_enc0", 32'(enc_valid[0]), 32'h63);
        check("b_out0", 32'(out_buf[0]), 32'h61);
        check("b_fin_cycle", 32'(fin), 32'd321);
        check("b_n_writes", 32'(n_writes), 32'd32);
        check("b_key_inv", 32'(kinv_at_fin), 32'd0);
        for (int a = 0; a < 256; a++) exp_pt[a] = (a < MSG_LEN) ? 8'h61 : 8'h00;
        check("b_all_a", 32'(count_diff(out_buf, exp_pt, MSG_LEN)), 32'd0);
        @(negedge clk);

        // Run C: reset during byte 5 (cycle 56 is its WR_J), then rerun.
        enc_use = CHK ? enc_valid : zeros;
        enc_mem = enc_use;
        load_identity();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 56; c++) @(negedge clk);
        check("c_wr_j_before_rst", 32'(s_write), 32'd1);
        rst = 1'b1;
        #1;
        check("c_rst_s_write",   32'(s_write),        32'd0);
        check("c_rst_out_write", 32'(out_write),      32'd0);
        check("c_rst_finish",    32'(decrypt_finish), 32'd0);
        check("c_rst_s_addr",    32'(s_addr),         32'd0);
        @(negedge clk);
        load_identity();
        rst = 1'b0;
        @(negedge clk);
        check("c_post_rst_strobes", {29'd0, s_write, out_write, decrypt_finish}, 32'd0);
        rc4_model(s_init, enc_use, CHK, exp_pt, exp_s, exp_n);
        do_run(1'b0, 0, fin);
        check("c_fin_cycle", 32'(fin), 32'd321);
        check("c_first_addr", 32'(first_out_addr), 32'd0);
        check("c_pt_vs_model", 32'(count_diff(out_buf, exp_pt, MSG_LEN)), 32'd0);
`ifndef RC4_ASCII_CHECK_EN
        check("c_out0", 32'(out_buf[0]), 32'h02);
        check("c_out2", 32'(out_buf[2]), 32'h07);
`endif
        @(negedge clk);

        // Run D: start pulsed mid-run, then held through DONE into a second run.
        load_identity();
        do_run(1'b1, 100, fin);
        check("d1_fin_cycle", 32'(fin), 32'd321);
        check("d1_pt_vs_model", 32'(count_diff(out_buf, exp_pt, MSG_LEN)), 32'd0);
        s_after = s_mem;
        @(negedge clk);
        check("d_finish_one_cycle", 32'(decrypt_finish), 32'd0);
        rc4_model(s_after, enc_use, CHK, exp_pt, exp_s, exp_n);
        do_run(1'b0, 0, fin);
        check("d2_fin_cycle", 32'(fin), 32'(10 * exp_n + 1));
        check("d2_first_addr", 32'(first_out_addr), 32'd0);
        check("d2_n_writes", 32'(n_writes), 32'(exp_n));
        check("d2_pt_vs_model", 32'(count_diff(out_buf, exp_pt, exp_n)), 32'd0);
        check("d2_sram_vs_model", 32'(count_diff(s_mem, exp_s, 256)), 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
